// File: rtl/unified_mem_arbiter.sv
// Arbitrates a single external memory port between instruction fetch and data
// accesses: one outstanding transaction, data side wins ties, bounded by a timeout.
module unified_mem_arbiter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_if_req,
  input  logic [WIDTH-1:0] i_if_addr,
  output logic [WIDTH-1:0] o_if_rdata,
  output logic             o_if_valid,
  input  logic             i_dm_req,
  input  logic             i_dm_we,
  input  logic [WIDTH-1:0] i_dm_addr,
  input  logic [WIDTH-1:0] i_dm_wdata,
  input  logic [3:0]       i_dm_byteen,
  output logic [WIDTH-1:0] o_dm_rdata,
  output logic             o_dm_valid,
  output logic             o_mem_valid,
  input  logic             i_mem_ready,
  output logic             o_mem_we,
  output logic [WIDTH-1:0] o_mem_addr,
  output logic [WIDTH-1:0] o_mem_wdata,
  output logic [3:0]       o_mem_byteen,
  input  logic             i_mem_rvalid,
  input  logic [WIDTH-1:0] i_mem_rdata,
  output logic             o_stall_if,
  output logic             o_stall_mem,
  output logic             o_err
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             owner_dm;
  logic             r_we;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [3:0]       r_byteen;
  logic [CW-1:0]    wait_cnt;
  logic [WIDTH-1:0] if_rdata;
  logic [WIDTH-1:0] dm_rdata;
  logic             err;
  logic             busy;
  logic             timeout;

  assign busy    = (state == S_ISSUE) || (state == S_WAIT);
  // The limit cycle itself withdraws the request, so the bus sees exactly MAX_WAIT valid cycles.
  assign timeout = busy && (wait_cnt == WAIT_LIMIT);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (i_dm_req || i_if_req) state_nx = S_ISSUE;
      S_ISSUE: begin
        if (timeout)          state_nx = S_RESP;
        else if (i_mem_ready) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (timeout)           state_nx = S_RESP;
        else if (i_mem_rvalid) state_nx = S_RESP;
      end
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      owner_dm <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_byteen <= '0;
      wait_cnt <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
      err      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          wait_cnt <= '0;
          if (i_dm_req) begin
            owner_dm <= 1'b1;
            r_we     <= i_dm_we;
            r_addr   <= i_dm_addr;
            r_wdata  <= i_dm_wdata;
            r_byteen <= i_dm_byteen;
          end else if (i_if_req) begin
            owner_dm <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= i_if_addr;
            r_wdata  <= '0;
            r_byteen <= '1;
          end
        end
        S_ISSUE, S_WAIT: begin
          if (timeout) begin
            err <= 1'b1;
            if (owner_dm) dm_rdata <= '0;
            else          if_rdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            // Responses are only accepted after the request handshake completed.
            if ((state == S_WAIT) && i_mem_rvalid && !r_we) begin
              if (owner_dm) dm_rdata <= i_mem_rdata;
              else          if_rdata <= i_mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_mem_valid  = (state == S_ISSUE) && !timeout;
  assign o_mem_we     = r_we;
  assign o_mem_addr   = r_addr;
  assign o_mem_wdata  = r_wdata;
  assign o_mem_byteen = r_byteen;

  assign o_if_valid  = (state == S_RESP) && !owner_dm;
  assign o_dm_valid  = (state == S_RESP) && owner_dm;
  assign o_if_rdata  = if_rdata;
  assign o_dm_rdata  = dm_rdata;
  assign o_err       = err;

  assign o_stall_if  = i_if_req & ~o_if_valid;
  assign o_stall_mem = i_dm_req & ~o_dm_valid;

endmodule
